// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared state encodings and widths for operand_loader
package operand_loader_pkg;
  localparam int OP_W = 32;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/operand_loader.sv
// operand_loader: packs 8 serial bytes into adder operands a,b (in_data/in_valid/in_ready in, a/b/op_valid/op_ready out, flush aborts)
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  output logic              op_valid,
  input  logic              op_ready
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d, cur, ins;
  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign op_valid = state_q == HOLD;
  assign a = a_q;
  assign b = b_q;
  always_comb begin
    cur = state_q == LOAD_A ? a_q : b_q;
    ins = cur;
    case (cnt_q)
      2'd0: if (LSB_FIRST) ins[7:0] = in_data; else ins[31:24] = in_data;
      2'd1: if (LSB_FIRST) ins[15:8] = in_data; else ins[23:16] = in_data;
      2'd2: if (LSB_FIRST) ins[23:16] = in_data; else ins[15:8] = in_data;
      default: if (LSB_FIRST) ins[31:24] = in_data; else ins[7:0] = in_data;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    if (flush) begin
      state_d = LOAD_A;
      cnt_d = 2'd0;
    end else if (state_q == HOLD) begin
      if (op_ready) begin
        state_d = LOAD_A;
        cnt_d = 2'd0;
      end
    end else if (!in_ready) begin
      state_d = LOAD_A;
      cnt_d = 2'd0;
    end else if (in_valid) begin
      cnt_d = cnt_q + 2'd1;
      a_d = state_q == LOAD_A ? ins : a_q;
      b_d = state_q == LOAD_B ? ins : b_q;
      if (cnt_q == 2'd3) state_d = state_q == LOAD_A ? LOAD_B : HOLD;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q <= 2'd0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed-vector bench for LSB-first and MSB-first loaders
module tb_operand_loader;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, op_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, op_valid, in_ready_m, op_valid_m;
  logic [31:0] a, b, a_m, b_m;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  operand_loader #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .op_valid(op_valid), .op_ready(op_ready)
  );
  operand_loader #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .a(a_m), .b(b_m), .op_valid(op_valid_m), .op_ready(op_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send8(input logic [63:0] bytes, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      in_data = bytes[63-8*i -: 8];
      in_valid = 1'b1;
      step();
      if (i == 6) check("op_valid_after7", {31'b0, op_valid}, 32'h0);
      if (gaps && i < 7) begin
        in_valid = 1'b0;
        in_data = 8'hEE;
        step();
      end
    end
    check("op_valid_after8", {31'b0, op_valid}, 32'h1);
    check("in_ready_hold", {31'b0, in_ready}, 32'h0);
  endtask
  task automatic handshake;
    in_valid = 1'b0;
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("hs_op_valid", {31'b0, op_valid}, 32'h0);
    check("hs_in_ready", {31'b0, in_ready}, 32'h1);
  endtask
  initial begin
    #1;
    check("rst_a", a, 32'h0);
    check("rst_b", b, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_op_valid", {31'b0, op_valid}, 32'h0);
    #11 rst_n = 1'b1;
    step();
    send8(64'h01000000_02000000, 1'b0);
    check("s1_a", a, 32'h00000001);
    check("s1_b", b, 32'h00000002);
    check("s1_msb_a", a_m, 32'h01000000);
    check("s1_msb_b", b_m, 32'h02000000);
    in_data = 8'hAA;
    repeat (2) step();
    check("s1_hold_a", a, 32'h00000001);
    check("s1_hold_valid", {31'b0, op_valid}, 32'h1);
    in_valid = 1'b1;
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    in_valid = 1'b0;
    check("s1_hs_op_valid", {31'b0, op_valid}, 32'h0);
    check("s1_hs_no_take_a", a, 32'h00000001);
    check("s1_keep_b", b, 32'h00000002);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("s1_ignore_op_ready", {31'b0, in_ready}, 32'h1);
    send8(64'hFFFF0000_C1CC0200, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("s2_hold_a", a, 32'h0000FFFF);
      check("s2_hold_b", b, 32'h0002CCC1);
      check("s2_hold_valid", {31'b0, op_valid}, 32'h1);
      step();
    end
    handshake();
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h11 * 8'(i + 1);
      in_valid = 1'b1;
      step();
    end
    check("s3_partial_a", a, 32'h44332211);
    check("s3_retain_b", b, 32'h0002CC55);
    in_data = 8'h66;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("s3_flush_b", b, 32'h0002CC55);
    check("s3_flush_a", a, 32'h44332211);
    check("s3_flush_in_ready", {31'b0, in_ready}, 32'h1);
    send8(64'hA0A1A2A3_A4A5A6A7, 1'b0);
    check("s3_fresh_a", a, 32'hA3A2A1A0);
    check("s3_fresh_b", b, 32'hA7A6A5A4);
    in_valid = 1'b0;
    flush = 1'b1;
    op_ready = 1'b1;
    step();
    flush = 1'b0;
    op_ready = 1'b0;
    check("s3_flush_hold_valid", {31'b0, op_valid}, 32'h0);
    check("s3_flush_hold_a", a, 32'hA3A2A1A0);
    send8(64'h12345678_9ABCDEF0, 1'b0);
    in_valid = 1'b0;
    check("s5_msb_a", a_m, 32'h12345678);
    check("s5_msb_b", b_m, 32'h9ABCDEF0);
    check("s5_lsb_a", a, 32'h78563412);
    check("s5_msb_valid", {31'b0, op_valid_m}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s4_rst_valid", {31'b0, op_valid}, 32'h0);
    check("s4_rst_a", a, 32'h0);
    check("s4_rst_b", b_m, 32'h0);
    check("s4_rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    op_ready = 1'b1;
    repeat (2) step();
    check("s4_no_transfer", {31'b0, op_valid}, 32'h0);
    check("s4_b_stays", b, 32'h0);
    send8(64'h01000000_02000000, 1'b1);
    check("s6_a", a, 32'h00000001);
    check("s6_b", b, 32'h00000002);
    in_valid = 1'b0;
    step();
    check("s6_hs_op_valid", {31'b0, op_valid}, 32'h0);
    op_ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
